// File: rtl/enc_pkg.sv
// Purpose: shared mode encodings and index-width helper for the priority encoder pipe.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   MODE_STRICT / MODE_LSB / MODE_MSB : per-beat encoding mode values (3 falls back to strict)
//   idx_w(width)                      : index width for a given request width, never below 1
package enc_pkg;

  localparam logic [1:0] MODE_STRICT = 2'd0;
  localparam logic [1:0] MODE_LSB    = 2'd1;
  localparam logic [1:0] MODE_MSB    = 2'd2;

  // Guards against a zero-width index if someone instantiates a degenerate width.
  function automatic int idx_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/enc_core.sv
// Purpose: combinational one-hot / LSB-priority / MSB-priority encoder with zero and multi-hot flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when the result is captured.
//
// Ports:
//   i_data  [WIDTH-1:0] request vector
//   i_mode  [1:0]       encoding mode (MODE_STRICT, MODE_LSB, MODE_MSB; 3 acts as strict)
//   o_index [IDX_W-1:0] encoded bit position, 0 when the vector is zero
//   o_zero              vector is all-zero
//   o_multi             more than one bit is set
module enc_core
  import enc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_mode,
  output logic [IDX_W-1:0] o_index,
  output logic             o_zero,
  output logic             o_multi
);

  logic [IDX_W-1:0] w_lsb;
  logic [IDX_W-1:0] w_msb;
  logic             w_found;

  always_comb begin
    w_lsb   = '0;
    w_msb   = '0;
    w_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i] && !w_found) begin
        w_lsb   = IDX_W'(i);
        w_found = 1'b1;
      end
      // Ascending scan: the last set bit seen is the highest one.
      if (i_data[i]) begin
        w_msb = IDX_W'(i);
      end
    end
  end

  always_comb begin
    o_zero  = ~|i_data;
    // Clearing the lowest set bit leaves something only if a second bit was set.
    o_multi = |(i_data & (i_data - WIDTH'(1)));
    case (i_mode)
      MODE_LSB: o_index = w_lsb;
      MODE_MSB: o_index = w_msb;
      // Strict: a single set bit is both lowest and highest; anything else encodes 0.
      default:  o_index = (o_zero || o_multi) ? '0 : w_lsb;
    endcase
  end

endmodule

// File: rtl/prio_enc_pipe.sv
// Purpose: two-stage pipelined priority encoder with valid/ready on both sides and a strict-mode error counter.
// Latency: 2 cycles from input presentation to out_valid (S1 then S2 register), 1 beat/cycle throughput.
// Backpressure: out_ready stalls S2, which stalls S1, which drops in_ready combinationally (no skid buffer).
//
// Ports:
//   clock, reset_n       rising-edge clock, synchronous active-low reset
//   enable               gates acceptance only; in-flight beats keep draining
//   mode [1:0]           per-beat encoding mode, sampled with the beat
//   in_valid/in_ready    input handshake, in_data [WIDTH-1:0] request vector
//   out_valid/out_ready  output handshake, out_index/out_zero/out_multi result
//   err_count [CNT_W-1:0] saturating count of delivered strict-mode zero/multi beats
//   clear_err            synchronous clear of err_count, wins over a same-cycle increment
module prio_enc_pipe
  import enc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [idx_w(WIDTH)-1:0]   out_index,
  output logic                      out_zero,
  output logic                      out_multi,
  output logic [CNT_W-1:0]          err_count,
  input  logic                      clear_err
);

  // Derived from WIDTH; intentionally not a parameter so it cannot be overridden.
  localparam int IDX_W = idx_w(WIDTH);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [1:0]       r_s1_mode;

  logic             r_s2_valid;
  logic [IDX_W-1:0] r_s2_index;
  logic             r_s2_zero;
  logic             r_s2_multi;
  logic             r_s2_err;

  logic [CNT_W-1:0] r_err_cnt;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [IDX_W-1:0] w_index;
  logic             w_zero;
  logic             w_multi;
  logic             w_s1_strict;

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign in_ready   = enable && w_s1_adv;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  // Mode 3 is treated as strict, so "strict" means neither priority mode.
  assign w_s1_strict = (r_s1_mode != MODE_LSB) && (r_s1_mode != MODE_MSB);

  enc_core #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc_core (
    .i_data  (r_s1_data),
    .i_mode  (r_s1_mode),
    .o_index (w_index),
    .o_zero  (w_zero),
    .o_multi (w_multi)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= MODE_STRICT;
      r_s2_valid <= 1'b0;
      r_s2_index <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_multi <= 1'b0;
      r_s2_err   <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      // When S1 advances its beat has moved on to S2, so it refills or empties.
      if (w_s1_adv) begin
        r_s1_valid <= w_in_fire;
        if (w_in_fire) begin
          r_s1_data <= in_data;
          r_s1_mode <= mode;
        end
      end

      // Result fields only load with a real beat so they hold while idle or stalled.
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_index <= w_index;
          r_s2_zero  <= w_zero;
          r_s2_multi <= w_multi;
          r_s2_err   <= w_s1_strict && (w_zero || w_multi);
        end
      end

      // Errors count when the beat is delivered, not when it is encoded.
      if (clear_err) begin
        r_err_cnt <= '0;
      end else if (w_out_fire && r_s2_err && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_index = r_s2_index;
  assign out_zero  = r_s2_zero;
  assign out_multi = r_s2_multi;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_prio_enc_pipe.sv
// Purpose: randomized and directed scoreboard bench for prio_enc_pipe (WIDTH=16, CNT_W=8).
// Latency: expects results 2 cycles after presentation with out_ready high.
// Backpressure: drives out_ready always-high, toggling, random or held low.
module tb_prio_enc_pipe;

  localparam int W  = 16;
  localparam int CW = 8;

  typedef struct {
    int idx;
    bit zero;
    bit multi;
    bit err;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_index;
  logic          out_zero;
  logic          out_multi;
  logic [CW-1:0] err_count;
  logic          clear_err = 1'b0;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  int   model_cnt = 0;
  int   rdy_mode = 0;     // 0 high, 1 toggle, 2 random, 3 low
  bit   en_rand = 1'b0;

  prio_enc_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_zero  (out_zero),
    .out_multi (out_multi),
    .err_count (err_count),
    .clear_err (clear_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: derived from the bit-level rules with plain integer arithmetic.
  function automatic exp_t ref_enc(input logic [W-1:0] d, input logic [1:0] m);
    exp_t r;
    int unsigned v;
    int n;
    int k;
    v = d;
    n = $countones(d);
    r.zero  = (v == 0);
    r.multi = (n > 1);
    r.idx   = 0;
    if (v != 0) begin
      if (m == 2'd1) begin
        k = 0;
        while (((v >> k) & 1) == 0) k++;
        r.idx = k;
      end else if (m == 2'd2) begin
        k = 0;
        while ((v >> (k + 1)) != 0) k++;
        r.idx = k;
      end else if (n == 1) begin
        k = 0;
        while ((1 << k) != v) k++;
        r.idx = k;
      end
    end
    r.err = (m != 2'd1) && (m != 2'd2) && (r.zero || r.multi);
    return r;
  endfunction

  // out_ready driver
  initial forever begin
    @(posedge clock);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // enable driver
  initial forever begin
    @(posedge clock);
    #1;
    enable = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    bit   stalled;
    int   h_idx;
    bit   h_zero;
    bit   h_multi;
    bit   inc;
    exp_t e;
    stalled = 1'b0;
    h_idx = 0;
    h_zero = 1'b0;
    h_multi = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        q.delete();
        model_cnt = 0;
        stalled = 1'b0;
      end else begin
        inc = 1'b0;
        check("err_count", int'(err_count), model_cnt);
        if (stalled) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_index", int'(out_index), h_idx);
          check("stall_zero", int'(out_zero), int'(h_zero));
          check("stall_multi", int'(out_multi), int'(h_multi));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got index %0d, expected no beat", out_index);
          end else begin
            e = q.pop_front();
            check("out_index", int'(out_index), e.idx);
            check("out_zero", int'(out_zero), int'(e.zero));
            check("out_multi", int'(out_multi), int'(e.multi));
            inc = e.err && (model_cnt < 255);
          end
        end
        if (clear_err) model_cnt = 0;
        else if (inc) model_cnt++;
        stalled = out_valid && !out_ready;
        h_idx   = int'(out_index);
        h_zero  = out_zero;
        h_multi = out_multi;
        if (in_valid && in_ready) q.push_back(ref_enc(in_data, mode));
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [1:0] m);
    int t;
    bit acc;
    t = 0;
    acc = 1'b0;
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    while (!acc) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      t++;
      if (!acc && t > 300) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got no in_ready in %0d cycles, expected acceptance", t);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = W'($urandom);
    mode     = 2'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 1000) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", q.size());
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [W-1:0] d;
    int t;

    // Reset
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_index", int'(out_index), 0);
    check("rst_out_zero", int'(out_zero), 0);
    check("rst_out_multi", int'(out_multi), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Strict one-hot and latency
    rdy_mode = 0;
    @(posedge clock);
    #1;
    send(16'h0400, 2'd0);
    check("lat_s1_only", int'(out_valid), 0);
    @(posedge clock);
    #1;
    check("lat_out_valid", int'(out_valid), 1);
    check("onehot_index", int'(out_index), 10);
    check("onehot_zero", int'(out_zero), 0);
    check("onehot_multi", int'(out_multi), 0);
    drain();

    // Priority modes do not count errors
    send(16'h8050, 2'd1);
    send(16'h8050, 2'd2);
    drain();
    check("prio_err_count", int'(err_count), 0);

    // Strict-mode zero and multi-hot
    send(16'h0000, 2'd0);
    send(16'h0003, 2'd0);
    drain();
    check("strict_err_count", int'(err_count), 2);

    // Stream under toggling backpressure
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(W'(1) << i, 2'd0);
    drain();

    // Randomized traffic with random ready and enable
    rdy_mode = 2;
    en_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = W'(1) << $urandom_range(0, W - 1);
        2:       d = W'($urandom);
        default: d = (W'(1) << $urandom_range(0, W - 1)) | (W'(1) << $urandom_range(0, W - 1));
      endcase
      send(d, 2'($urandom_range(0, 3)));
    end
    en_rand = 1'b0;
    drain();

    // Saturation
    rdy_mode = 0;
    clear_err = 1'b1;
    @(posedge clock);
    #1;
    clear_err = 1'b0;
    for (int i = 0; i < 300; i++) send('0, 2'd0);
    drain();
    check("err_saturated", int'(err_count), 255);

    // Clear wins over a same-cycle increment
    rdy_mode = 3;
    repeat (2) @(posedge clock);
    #1;
    send('0, 2'd0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clock);
      #1;
      t++;
    end
    check("clr_beat_waiting", int'(out_valid), 1);
    rdy_mode = 0;
    @(posedge clock);
    #1;
    clear_err = 1'b1;
    @(posedge clock);
    #1;
    clear_err = 1'b0;
    check("clear_wins", int'(err_count), 0);
    drain();

    // Reset with both stages full discards everything
    send('0, 2'd3);
    drain();
    check("pre_reset_err", int'(err_count), 1);
    rdy_mode = 3;
    repeat (2) @(posedge clock);
    #1;
    send(16'h0010, 2'd1);
    send(16'h0020, 2'd2);
    check("full_in_ready", int'(in_ready), 0);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("flush_out_valid", int'(out_valid), 0);
    check("flush_err_count", int'(err_count), 0);
    rdy_mode = 0;
    repeat (6) @(posedge clock);
    #1;
    check("flush_no_stale", int'(out_valid), 0);
    send(16'h0100, 2'd0);
    drain();

    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
